// File: rtl/demux_1to2_8b_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : demux_1to2_8b_buf
//  Purpose  : 1-to-2 byte demultiplexer with a small FIFO per output channel.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Per-channel FIFO: occupancy-counted, zero data output when empty.
// ----------------------------------------------------------------------------
module demux_1to2_8b_buf_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop_req,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_full
);

    localparam logic [AW:0]   C_DEPTH   = DEPTH;
    localparam logic [AW:0]   C_CNT_ONE = 1;
    localparam logic [AW-1:0] C_PTR_ONE = 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == C_DEPTH);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop_req && !w_empty;

    // Storage is not reset; the output mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? 8'h00 : r_mem[r_rptr];

endmodule

// ----------------------------------------------------------------------------
//  Top: route each accepted byte to channel A (sel=0) or B (sel=1).
// ----------------------------------------------------------------------------
module demux_1to2_8b_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_a_data,
    output logic       out_a_valid,
    input  logic       out_a_ready,
    output logic [7:0] out_b_data,
    output logic       out_b_valid,
    input  logic       out_b_ready,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);

    logic       w_full_a;
    logic       w_full_b;
    logic       w_accept;
    logic       w_push_a;
    logic       w_push_b;
    logic [7:0] r_cnt_a;
    logic [7:0] r_cnt_b;

    // Ready looks only at the selected channel's occupancy, never at consumers.
    assign in_ready = in_sel ? !w_full_b : !w_full_a;
    assign w_accept = in_valid && in_ready;
    assign w_push_a = w_accept && !in_sel;
    assign w_push_b = w_accept &&  in_sel;

    demux_1to2_8b_buf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push_a),
        .i_data    (in_data),
        .i_pop_req (out_a_ready),
        .o_data    (out_a_data),
        .o_valid   (out_a_valid),
        .o_full    (w_full_a)
    );

    demux_1to2_8b_buf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push_b),
        .i_data    (in_data),
        .i_pop_req (out_b_ready),
        .o_data    (out_b_data),
        .o_valid   (out_b_valid),
        .o_full    (w_full_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= 8'h00;
            r_cnt_b <= 8'h00;
        end else begin
            if (w_push_a) begin
                r_cnt_a <= r_cnt_a + 8'h01;
            end
            if (w_push_b) begin
                r_cnt_b <= r_cnt_b + 8'h01;
            end
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;

endmodule
`default_nettype wire

// File: tb/tb_demux_1to2_8b_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1to2_8b_buf
//  Purpose  : Directed scoreboard bench for demux_1to2_8b_buf.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_1to2_8b_buf;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_a_data;
    logic       out_a_valid;
    logic       out_a_ready;
    logic [7:0] out_b_data;
    logic       out_b_valid;
    logic       out_b_ready;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] exp_cnt_a = 8'h00;
    logic [7:0] exp_cnt_b = 8'h00;

    demux_1to2_8b_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then advance the model with the
    // handshakes that will occur at the coming rising edge.
    task automatic tick();
        logic       exp_rdy;
        logic [7:0] exp_da;
        logic [7:0] exp_db;
        #1;
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_a_valid",  32'(out_a_valid), 32'd0);
            chk("rst_a_data",   32'(out_a_data), 32'd0);
            chk("rst_b_valid",  32'(out_b_valid), 32'd0);
            chk("rst_b_data",   32'(out_b_data), 32'd0);
            chk("rst_cnt_a",    32'(cnt_a), 32'd0);
            chk("rst_cnt_b",    32'(cnt_b), 32'd0);
        end else begin
            exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
            exp_da  = 8'h00;
            exp_db  = 8'h00;
            if (qa.size() != 0) exp_da = qa[0];
            if (qb.size() != 0) exp_db = qb[0];
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("a_valid",  32'(out_a_valid), 32'(qa.size() != 0));
            chk("a_data",   32'(out_a_data), 32'(exp_da));
            chk("b_valid",  32'(out_b_valid), 32'(qb.size() != 0));
            chk("b_data",   32'(out_b_data), 32'(exp_db));
            chk("cnt_a",    32'(cnt_a), 32'(exp_cnt_a));
            chk("cnt_b",    32'(cnt_b), 32'(exp_cnt_b));
            if (qa.size() != 0 && out_a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && out_b_ready) void'(qb.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) begin
                    qb.push_back(in_data);
                    exp_cnt_b = exp_cnt_b + 8'h01;
                end else begin
                    qa.push_back(in_data);
                    exp_cnt_a = exp_cnt_a + 8'h01;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_data     = 8'h00;
        in_sel      = 1'b0;
        in_valid    = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;

        // Reset then idle, in_ready for both selects
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        in_sel = 1'b1;
        tick();

        // Basic routing
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5; tick();
        in_sel = 1'b1; in_data = 8'h3C; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Fill A under backpressure, third byte held
        out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        in_data = 8'h03; tick(); tick();
        chk("a_full_stall", 32'(in_ready), 32'd0);

        // B still accepts while A is full
        in_sel = 1'b1; in_data = 8'hFF; tick();
        in_sel = 1'b0; in_data = 8'h03; tick();
        chk("a_head_kept", 32'(out_a_data), 32'h01);

        // Release A, drain in order
        out_a_ready = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Simultaneous push and pop on A with one byte resident
        out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11; tick();
        out_a_ready = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // 256 pushes to B: counter wraps back to its starting value
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("cnt_b_wrap", 32'(cnt_b), 32'(exp_cnt_b));

        // Asynchronous reset mid-burst with A holding two bytes
        out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0;
        in_data = 8'hC1; tick();
        in_data = 8'hC2; tick();
        in_sel = 1'b1; in_data = 8'hD0; tick();
        chk("pre_rst_a_valid", 32'(out_a_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_a_valid", 32'(out_a_valid), 32'd0);
        chk("async_a_data",  32'(out_a_data), 32'd0);
        chk("async_b_valid", 32'(out_b_valid), 32'd0);
        chk("async_cnt_a",   32'(cnt_a), 32'd0);
        chk("async_cnt_b",   32'(cnt_b), 32'd0);
        qa.delete();
        qb.delete();
        exp_cnt_a = 8'h00;
        exp_cnt_b = 8'h00;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tick(); tick();
        rst_n = 1'b1;
        out_a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77; tick();
        in_valid = 1'b0;
        chk("post_rst_head", 32'(out_a_data), 32'h77);
        for (int i = 0; i < 3; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1to2_8b_buf.md
Name: demux_1to2_8b_buf

Overview:
- Counterpart of the 2-to-1 8-bit mux: takes one 8-bit valid/ready byte stream and routes each byte to one of two output channels (A or B), chosen by a per-byte select bit.
- Each channel has its own small FIFO, so a stalled consumer on one side does not block bytes bound for the other side unless the input is currently selecting that side.
- Sits between the CPU data bus and two destination units, for example the register file and the output port.

Parameters:
- DEPTH, 2, entries per channel FIFO; power of two, DEPTH >= 2.
- AW, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  byte to route.
- in_sel  input  1  0 routes to channel A, 1 routes to channel B; sampled with in_data.
- in_valid  input  1  in_data/in_sel are valid.
- in_ready  output  1  block accepts the byte this cycle.
- out_a_data  output  8  channel A head byte.
- out_a_valid  output  1  channel A FIFO non-empty.
- out_a_ready  input  1  channel A consumer accepts.
- out_b_data  output  8  channel B head byte.
- out_b_valid  output  1  channel B FIFO non-empty.
- out_b_ready  input  1  channel B consumer accepts.
- cnt_a  output  8  bytes accepted for A since reset, wraps at 255->0.
- cnt_b  output  8  bytes accepted for B since reset, wraps at 255->0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous), applied at any time including mid-transfer:
  - Both FIFOs flush: pointers and occupancy go to 0.
  - out_a_valid=0, out_b_valid=0, cnt_a=0, cnt_b=0.
  - out_*_data reads 8'h00.
  - Storage contents need not clear, but data outputs are forced to 0 while the FIFO is empty.
- Push and pop rules:
  - in_ready is combinational: in_ready = !full_A when in_sel=0, else !full_B. It depends only on in_sel and the occupancy registers, not on out_*_ready.
  - Push: when in_valid && in_ready at a rising edge, the selected FIFO writes in_data and the matching counter increments by 1 (8-bit wrap).
  - Pop: when out_x_valid && out_x_ready at a rising edge, FIFO x advances its read pointer.
  - Each channel is independent. Channel A and channel B may pop in the same cycle, and one may push while the other pops.
- Latency: no bypass. A byte pushed at edge N appears on out_x_data with out_x_valid=1 after edge N, i.e. it is visible in cycle N+1. Minimum latency is 1 cycle.
- Ordering: bytes within one channel leave in acceptance order. No ordering is defined between channels.
- Per-channel occupancy, range 0..DEPTH:
  - Push only: +1. Pop only: -1.
  - Push and pop in the same cycle when non-empty: unchanged, and the head advances.
  - Push and pop in the same cycle when empty: impossible, since out_valid=0.
  - Push when full: impossible, since in_ready=0.
- Full stall: when the selected FIFO is full, in_ready=0. The source must hold in_data/in_sel/in_valid stable.
  - If the source changes in_sel to the non-full channel while waiting, in_ready follows immediately. This is legal.
  - The block keeps no "pending" state.
- Pointers: AW-bit read/write pointers wrap modulo DEPTH. Full and empty are derived from an (AW+1)-bit occupancy count, not from pointer equality alone.
- Output stability: out_x_data and out_x_valid change only on clock edges or on reset assertion.
- in_valid=0: nothing is written and the counters hold, regardless of in_sel.
- No X on outputs after reset; in_ready is defined even when in_valid=0.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, release, in_valid=0 for 5 cycles -> all valids 0, cnt_a=cnt_b=0, in_ready=1 for both in_sel values.
- Basic routing: push 8'hA5 sel=0, then 8'h3C sel=1, both readys=1 -> out_a_data=8'hA5 with valid one cycle after acceptance; out_b_data=8'h3C one cycle after its acceptance; cnt_a=1, cnt_b=1.
- Full and backpressure on A: out_a_ready=0, push 8'h01,8'h02,8'h03 sel=0 -> first two accepted, in_ready=0 while the third is held. Raise out_a_ready -> outputs 8'h01, 8'h02, 8'h03 in order; cnt_a=3.
- Independence: A full with out_a_ready=0; switch in_sel=1 and push 8'hFF -> in_ready=1 and B receives 8'hFF. A contents stay unchanged (8'h01,8'h02 still queued).
- Simultaneous push and pop: A holds one byte, out_a_ready=1, push 8'h55 sel=0 every cycle for 10 cycles -> occupancy stays 1, in_ready never drops, output sequence matches input; cnt_a increments by 10.
- Counter wrap and mid-run reset:
  - 256 pushes to B -> cnt_b wraps to 0.
  - Assert rst_n mid-burst with A holding 2 bytes -> out_a_valid=0 and counters 0 immediately, without waiting for a clock. After release, the first new push to A appears first.
